aes_key_expander: RTL and testbench

Round-key generator for the AES accelerator: responds to the key-load side of the host interface (`key_len`, `short_key`, `key_exp_status`, `error`). It expands a 128/192/256-bit cipher key into the full FIPS-197 schedule, one 32-bit word per step. It borrows the core's combinational S-box through a byte-serial port and serves round keys to the round datapath by index.

---
 rtl/aes_key_expander_if.sv | 23 ++
 rtl/aes_key_expander.sv | 184 ++++++++++++++++++
 tb/tb_aes_key_expander.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expander_if.sv
// Key-load and round-key bus between the AES core and the key expander.
// Latency: n/a (signal bundle only).
// Backpressure: none; the master owns key_len/short_key/rk_idx and the S-box result.
interface aes_key_expander_if;
   logic [1:0]   key_len;
   logic [255:0] short_key;
   logic         key_exp_status;
   logic         error;
   logic [7:0]   sbox_in;
   logic [7:0]   sbox_out;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   modport master (
      output key_len, short_key, sbox_out, rk_idx,
      input  key_exp_status, error, sbox_in, rk_out
   );

   modport slave (
      input  key_len, short_key, sbox_out, rk_idx,
      output key_exp_status, error, sbox_in, rk_out
   );
endinterface

// File: rtl/aes_key_expander.sv
// Round-key generator: expands a 128/192/256-bit key into the FIPS-197 word schedule.
// Latency: load edge L, schedule valid on edge L+70/L+70/L+91; rk_out one edge after rk_idx.
// Backpressure: none; a load request while expanding is dropped and flagged with a 1-cycle error.
module aes_key_expander (
   input logic               clk,
   input logic               reset,
   aes_key_expander_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      EXPAND = 2'b01,
      DONE   = 2'b10
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    i_q, i_d;           // index of the word being produced
   logic [2:0]    j_q, j_d;           // i mod Nk, kept as a wrapping counter
   logic [1:0]    sub_cnt_q, sub_cnt_d;
   logic [23:0]   hold_q, hold_d;     // first three substituted bytes of a SubWord
   logic [7:0]    rcon_q, rcon_d;
   logic [3:0]    nk_q, nk_d;
   logic [3:0]    nr_q, nr_d;
   logic [5:0]    last_q, last_d;     // index of the final schedule word
   logic          status_q, status_d;
   logic          error_q, error_d;
   logic [127:0]  rk_q, rk_d;

   logic [31:0]   w_q [60];           // schedule storage, deliberately not reset

   logic          key_load;
   logic          w_we;
   logic [31:0]   w_wdata;
   logic          is_rot, is_sub;
   logic [31:0]   prev_w, src_w, old_w, sub_w, temp_w;
   logic [7:0]    sbox_byte;
   logic [5:0]    rk_base;

   assign is_rot = (j_q == 3'd0);
   assign is_sub = is_rot || ((nk_q == 4'd8) && (j_q == 3'd4));

   // S-box byte selection: purely from registered state so the shared S-box sees no loop
   always_comb begin
      prev_w    = '0;
      src_w     = '0;
      sbox_byte = 8'h00;
      if (state_q == EXPAND && is_sub) begin
         prev_w = w_q[i_q - 6'd1];
         src_w  = is_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;
         case (sub_cnt_q)
            2'd0:    sbox_byte = src_w[31:24];
            2'd1:    sbox_byte = src_w[23:16];
            2'd2:    sbox_byte = src_w[15:8];
            default: sbox_byte = src_w[7:0];
         endcase
      end
   end

   // Next-state and expansion datapath
   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      j_d       = j_q;
      sub_cnt_d = sub_cnt_q;
      hold_d    = hold_q;
      rcon_d    = rcon_q;
      nk_d      = nk_q;
      nr_d      = nr_q;
      last_d    = last_q;
      status_d  = status_q;
      error_d   = 1'b0;
      key_load  = 1'b0;
      w_we      = 1'b0;
      w_wdata   = '0;
      old_w     = '0;
      sub_w     = '0;
      temp_w    = '0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.key_len != 2'b00) begin
               case (bus.key_len)
                  2'b01: begin nk_d = 4'd4; nr_d = 4'd10; last_d = 6'd43; end
                  2'b10: begin nk_d = 4'd6; nr_d = 4'd12; last_d = 6'd51; end
                  default: begin nk_d = 4'd8; nr_d = 4'd14; last_d = 6'd59; end
               endcase
               key_load  = 1'b1;
               state_d   = EXPAND;
               status_d  = 1'b0;
               i_d       = {2'b00, nk_d};
               j_d       = 3'd0;
               rcon_d    = 8'h01;
               sub_cnt_d = 2'd0;
            end
         end
         EXPAND: begin
            if (bus.key_len != 2'b00)
               error_d = 1'b1;
            old_w = w_q[i_q - {2'b00, nk_q}];
            if (is_sub) begin
               sub_w  = {hold_q, bus.sbox_out};
               temp_w = is_rot ? (sub_w ^ {rcon_q, 24'h000000}) : sub_w;
               if (sub_cnt_q != 2'd3) begin
                  hold_d    = {hold_q[15:0], bus.sbox_out};
                  sub_cnt_d = sub_cnt_q + 2'd1;
               end else begin
                  sub_cnt_d = 2'd0;
                  if (is_rot)
                     rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               end
            end else begin
               temp_w = w_q[i_q - 6'd1];
            end
            if (!is_sub || sub_cnt_q == 2'd3) begin
               w_we    = 1'b1;
               w_wdata = old_w ^ temp_w;
               if (i_q == last_q) begin
                  state_d  = DONE;
                  status_d = 1'b1;
               end else begin
                  i_d = i_q + 6'd1;
                  j_d = ({1'b0, j_q} == nk_q - 4'd1) ? 3'd0 : j_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Round-key read mux: only a complete schedule is ever visible
   always_comb begin
      rk_d    = '0;
      rk_base = {bus.rk_idx, 2'b00};
      if (state_q == DONE && bus.rk_idx <= nr_q)
         rk_d = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         i_q       <= 6'd0;
         j_q       <= 3'd0;
         sub_cnt_q <= 2'd0;
         hold_q    <= '0;
         rcon_q    <= 8'h01;
         nk_q      <= 4'd4;
         nr_q      <= 4'd0;
         last_q    <= 6'd0;
         status_q  <= 1'b0;
         error_q   <= 1'b0;
         rk_q      <= '0;
      end else begin
         state_q   <= state_d;
         i_q       <= i_d;
         j_q       <= j_d;
         sub_cnt_q <= sub_cnt_d;
         hold_q    <= hold_d;
         rcon_q    <= rcon_d;
         nk_q      <= nk_d;
         nr_q      <= nr_d;
         last_q    <= last_d;
         status_q  <= status_d;
         error_q   <= error_d;
         rk_q      <= rk_d;
      end
   end

   // Word storage: cipher key words on load, one expanded word per completed step
   always_ff @(posedge clk) begin
      if (key_load) begin
         for (int k = 0; k < 8; k++)
            if (k < int'(nk_d))
               w_q[k] <= bus.short_key[255 - 32*k -: 32];
      end else if (w_we) begin
         w_q[i_q] <= w_wdata;
      end
   end

   assign bus.key_exp_status = status_q;
   assign bus.error          = error_q;
   assign bus.sbox_in        = sbox_byte;
   assign bus.rk_out         = rk_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors, load collision, reload, reset, random keys.
// Latency: checks status edge at L+70/L+91 and one-edge round-key reads.
// Backpressure: bench acts as host and as the combinational S-box.
module tb_aes_key_expander;

   logic clk = 1'b0;
   logic reset;

   aes_key_expander_if bus ();

   aes_key_expander dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [7:0]  sbox_tab [256];
   assign bus.sbox_out = sbox_tab[bus.sbox_in];

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   typedef struct {
      logic [1:0]   kl;
      logic [255:0] key;
      int           lat;
      int           idx;
      logic [127:0] rk;
   } vec_t;

   vec_t tbl [5];

   logic [31:0] ref_w [60];
   int          ref_lat;
   int          ref_nr;
   int          n_checks = 0;
   int          n_fail   = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox_tab[v[31:24]], sbox_tab[v[23:16]], sbox_tab[v[15:8]], sbox_tab[v[7:0]]};
   endfunction

   // Reference schedule straight from the FIPS-197 recurrence, plus the cycle cost per word
   task automatic ref_expand(input logic [1:0] kl, input logic [255:0] key);
      int         nk;
      int         total;
      logic [31:0] t;
      logic [7:0]  rc;
      nk      = (kl == 2'b01) ? 4 : (kl == 2'b10) ? 6 : 8;
      ref_nr  = nk + 6;
      total   = 4 * (ref_nr + 1);
      ref_lat = 0;
      rc      = 8'h01;
      for (int k = 0; k < nk; k++) ref_w[k] = key[255 - 32*k -: 32];
      for (int k = nk; k < total; k++) begin
         t = ref_w[k-1];
         if (k % nk == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
            ref_lat += 4;
         end else if (nk == 8 && k % 8 == 4) begin
            t = sub_word(t);
            ref_lat += 4;
         end else begin
            ref_lat += 1;
         end
         ref_w[k] = ref_w[k-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] ref_rk(input int idx);
      if (idx > ref_nr) return '0;
      return {ref_w[4*idx], ref_w[4*idx+1], ref_w[4*idx+2], ref_w[4*idx+3]};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_load(input logic [1:0] kl, input logic [255:0] key);
      @(negedge clk);
      bus.key_len   = kl;
      bus.short_key = key;
      @(posedge clk);
      #1;
      bus.key_len = 2'b00;
      check("status_low_after_load", bus.key_exp_status, 0);
   endtask

   task automatic wait_done(input int start, output int n);
      n = start;
      while (n < 300) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.key_exp_status) break;
      end
   endtask

   task automatic read_rk(input int idx, output logic [127:0] v);
      @(negedge clk);
      bus.rk_idx = 4'(idx);
      @(posedge clk);
      #1;
      v = bus.rk_out;
   endtask

   task automatic run_full(input string name, input logic [1:0] kl, input logic [255:0] key);
      int          lat;
      logic [127:0] v;
      ref_expand(kl, key);
      do_load(kl, key);
      wait_done(0, lat);
      check({name, "_latency"}, lat, ref_lat);
      for (int r = 0; r < 16; r++) begin
         read_rk(r, v);
         check($sformatf("%s_rk%0d", name, r), v, ref_rk(r));
      end
   endtask

   initial begin
      int           lat;
      logic [127:0] v;
      logic [7:0]   inv;
      logic [1:0]   kl;
      logic [255:0] key;

      // S-box from its definition: GF(2^8) inverse followed by the affine map
      for (int b = 0; b < 256; b++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_tab[b] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                     ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end

      tbl[0] = '{2'b01, K128, 70, 1,  128'ha0fafe1788542cb123a339392a6c7605};
      tbl[1] = '{2'b01, K128, 70, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      tbl[2] = '{2'b10, K192, 70, 12, 128'he98ba06f448c773c8ecc720401002202};
      tbl[3] = '{2'b11, K256, 91, 14, 128'hfe4890d1e6188d0b046df344706c631e};
      tbl[4] = '{2'b11, K256, 91, 15, 128'h0};

      reset         = 1'b0;
      bus.key_len   = 2'b00;
      bus.short_key = '0;
      bus.rk_idx    = 4'd0;
      #12;
      check("reset_status", bus.key_exp_status, 0);
      check("reset_error",  bus.error, 0);
      check("reset_sbox_in", bus.sbox_in, 0);
      check("reset_rk_out", bus.rk_out, 0);
      @(negedge clk);
      reset = 1'b1;

      // Known-answer vectors
      for (int t = 0; t < 5; t++) begin
         do_load(tbl[t].kl, tbl[t].key);
         wait_done(0, lat);
         check($sformatf("vec%0d_latency", t), lat, tbl[t].lat);
         read_rk(tbl[t].idx, v);
         check($sformatf("vec%0d_rk%0d", t, tbl[t].idx), v, tbl[t].rk);
      end

      // Load request in the middle of an AES-128 expansion
      do_load(2'b01, K128);
      bus.rk_idx = 4'd1;
      repeat (19) @(posedge clk);
      @(negedge clk);
      bus.key_len   = 2'b11;
      bus.short_key = K256;
      @(posedge clk);
      #1;
      bus.key_len = 2'b00;
      check("collision_error_high", bus.error, 1);
      @(posedge clk);
      #1;
      check("collision_error_low", bus.error, 0);
      check("collision_rk_hidden", bus.rk_out, 0);
      wait_done(21, lat);
      check("collision_latency", lat, 70);
      read_rk(10, v);
      check("collision_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      read_rk(11, v);
      check("aes128_rk11_zero", v, 0);

      // Reload from DONE with the AES-256 key
      ref_expand(2'b11, K256);
      do_load(2'b11, K256);
      wait_done(0, lat);
      check("reload_latency", lat, 91);
      read_rk(11, v);
      check("reload_rk11", v, ref_rk(11));
      check("reload_rk11_nonzero", v != 0, 1);

      // Asynchronous reset in the middle of an expansion
      do_load(2'b01, K128);
      repeat (34) @(posedge clk);
      @(negedge clk);
      bus.key_len = 2'b10;
      @(posedge clk);
      #1;
      bus.key_len = 2'b00;
      check("pre_reset_error", bus.error, 1);
      reset = 1'b0;
      #1;
      check("midreset_status", bus.key_exp_status, 0);
      check("midreset_error",  bus.error, 0);
      check("midreset_rk_out", bus.rk_out, 0);
      check("midreset_sbox_in", bus.sbox_in, 0);
      @(negedge clk);
      reset = 1'b1;
      run_full("after_reset", 2'b01, K128);

      // Random keys, including junk in the unused low key bits
      for (int n = 0; n < 6; n++) begin
         kl  = 2'($urandom_range(1, 3));
         key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         run_full($sformatf("rand%0d", n), kl, key);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
